// File: rtl/dp_pkg.sv
// Shared data-plane definitions: FSM state encoding, packet layout and the
// constants the transmitter and the remote receiver must agree on.
package dp_pkg;

    localparam int          PKT_LEN = 5;
    localparam logic [15:0] IDLE_ID = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQUEST = 2'd1,
        SEND    = 2'd2,
        DONE    = 2'd3
    } tx_state_t;

    typedef struct packed {
        logic [15:0] dest;
        logic [15:0] data;
    } dp_packet_t;

endpackage

// File: rtl/tx_fifo.sv
// Register-array FIFO holding payload words between the GPP and the link.
// Pointers wrap modulo DEPTH; a separate count disambiguates full from empty.
module tx_fifo #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage carries no reset; only pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/data_plane_tx.sv
// Data-plane transmitter: buffers GPP payload words, requests the link and
// emits a fixed-length burst of {dest, payload} packets once granted.
//
//   state   | meaning
//   IDLE    | waiting for a send request with enough words buffered
//   REQUEST | tx_req held high until the control plane grants the link
//   SEND    | one packet per cycle, PKT_LEN packets, grant ignored
//   DONE    | last packet on the wire; completion flag registered next edge
module data_plane_tx #(
    parameter int                DATA_W  = 16,
    parameter int                DEPTH   = 16,
    parameter int                PKT_LEN = 5,
    parameter logic [DATA_W-1:0] IDLE_ID = 16'hFFFF
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     gpp_wr_en,
    input  logic [DATA_W-1:0]        gpp_wr_data,
    input  logic                     gpp_send_req,
    input  logic [DATA_W-1:0]        dest_id,
    input  logic                     tx_grant,
    output logic                     tx_req,
    output logic                     tx_busy,
    output logic [2*DATA_W-1:0]      data_tx_packet,
    output logic                     data_tx_complete_flag,
    output logic                     wr_overflow,
    output logic [$clog2(DEPTH):0]   fifo_count
);

    import dp_pkg::*;

    localparam int CW  = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam int FCW = $clog2(DEPTH) + 1;
    localparam logic [2*DATA_W-1:0] IDLE_PKT = {IDLE_ID, {DATA_W{1'b0}}};

    tx_state_t         state;
    logic [DATA_W-1:0] dest_q;
    logic [CW-1:0]     pkt_cnt;
    logic [DATA_W-1:0] rd_data;
    logic              rd_en;
    logic              fifo_full;
    logic              fifo_empty;

    assign rd_en   = (state == SEND) && !fifo_empty;
    assign tx_busy = (state != IDLE);

    tx_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (gpp_wr_en),
        .wr_data (gpp_wr_data),
        .rd_en   (rd_en),
        .rd_data (rd_data),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_overflow <= 1'b0;
        end else begin
            wr_overflow <= gpp_wr_en && fifo_full;
        end
    end

    // Packet register defaults to the idle pattern so no receiver ever
    // matches it outside a burst.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                 <= IDLE;
            dest_q                <= IDLE_ID;
            pkt_cnt               <= '0;
            tx_req                <= 1'b0;
            data_tx_packet        <= IDLE_PKT;
            data_tx_complete_flag <= 1'b0;
        end else begin
            data_tx_packet        <= IDLE_PKT;
            data_tx_complete_flag <= 1'b0;
            case (state)
                IDLE: begin
                    if (gpp_send_req && (fifo_count >= FCW'(PKT_LEN))) begin
                        dest_q <= dest_id;
                        tx_req <= 1'b1;
                        state  <= REQUEST;
                    end
                end
                REQUEST: begin
                    if (tx_grant) begin
                        tx_req  <= 1'b0;
                        pkt_cnt <= '0;
                        state   <= SEND;
                    end
                end
                SEND: begin
                    data_tx_packet <= {dest_q, rd_data};
                    pkt_cnt        <= pkt_cnt + CW'(1);
                    if (pkt_cnt == CW'(PKT_LEN - 1)) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    data_tx_complete_flag <= 1'b1;
                    state                 <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_data_plane_tx.sv
// Scoreboard bench for data_plane_tx: stimulus queues expected packets, an
// independent monitor pops and compares them as they appear on the link.
module tb_data_plane_tx;

    localparam int PKT_LEN = 5;
    localparam logic [31:0] IDLE_PKT = 32'hFFFF0000;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        gpp_wr_en = 1'b0;
    logic [15:0] gpp_wr_data = '0;
    logic        gpp_send_req = 1'b0;
    logic [15:0] dest_id = '0;
    logic        tx_grant = 1'b0;
    logic        tx_req;
    logic        tx_busy;
    logic [31:0] data_tx_packet;
    logic        data_tx_complete_flag;
    logic        wr_overflow;
    logic [4:0]  fifo_count;

    data_plane_tx dut (
        .clk                   (clk),
        .rst                   (rst),
        .gpp_wr_en             (gpp_wr_en),
        .gpp_wr_data           (gpp_wr_data),
        .gpp_send_req          (gpp_send_req),
        .dest_id               (dest_id),
        .tx_grant              (tx_grant),
        .tx_req                (tx_req),
        .tx_busy               (tx_busy),
        .data_tx_packet        (data_tx_packet),
        .data_tx_complete_flag (data_tx_complete_flag),
        .wr_overflow           (wr_overflow),
        .fifo_count            (fifo_count)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] expq[$];
    logic [15:0] mq[$];
    int          exp_flags = 0;
    int          flags_seen = 0;
    int          exp_ovf = 0;
    int          ovf_seen = 0;
    int          burst = 0;
    int          last_pkt_cyc = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: packets, completion flag and overflow pulses.
    always @(negedge clk) begin
        if (!rst) begin
            burst = 0;
        end else begin
            if (data_tx_packet[31:16] != 16'hFFFF) begin
                if (expq.size() == 0) chk("pkt_unexpected", data_tx_packet, IDLE_PKT);
                else chk("pkt", data_tx_packet, expq.pop_front());
                burst++;
                last_pkt_cyc = cyc;
            end
            if (data_tx_complete_flag) begin
                flags_seen++;
                chk("burst_len", burst, PKT_LEN);
                chk("flag_gap", cyc - last_pkt_cyc, 1);
                burst = 0;
            end
            if (wr_overflow) ovf_seen++;
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wr(input logic [15:0] w);
        bit full_b;
        full_b = (mq.size() >= 16);
        gpp_wr_en = 1'b1;
        gpp_wr_data = w;
        tick();
        gpp_wr_en = 1'b0;
        if (full_b) exp_ovf++;
        else mq.push_back(w);
        chk("wr_overflow", wr_overflow, full_b);
    endtask

    task automatic transfer(input logic [15:0] d, input int gdly, input bit cw);
        int f0;
        int exp_c;
        gpp_send_req = 1'b1;
        dest_id = d;
        tick();
        gpp_send_req = 1'b0;
        chk("req_tx_req", tx_req, 1);
        chk("req_busy", tx_busy, 1);
        exp_c = mq.size();
        for (int i = 0; i < PKT_LEN; i++) expq.push_back({d, mq.pop_front()});
        exp_flags++;
        f0 = flags_seen;
        for (int i = 0; i < gdly; i++) begin
            tick();
            chk("wait_tx_req", tx_req, 1);
        end
        tx_grant = 1'b1;
        tick();
        tx_grant = 1'b0;
        chk("grant_tx_req", tx_req, 0);
        if (cw) begin
            gpp_wr_en = 1'b1;
            for (int i = 0; i < PKT_LEN; i++) begin
                gpp_wr_data = 16'(16'hAAA0 + i);
                tick();
                chk("cw_count", fifo_count, exp_c);
                mq.push_back(16'(16'hAAA0 + i));
            end
            gpp_wr_en = 1'b0;
        end
        for (int i = 0; i < 20 && flags_seen == f0; i++) tick();
        chk("flag_seen", flags_seen, f0 + 1);
        chk("post_count", fifo_count, mq.size());
        chk("post_busy", tx_busy, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d compared", n_cmp);
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset then idle
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("idle_pkt", data_tx_packet, IDLE_PKT);
            chk("idle_tx_req", tx_req, 0);
            chk("idle_count", fifo_count, 0);
            chk("idle_busy", tx_busy, 0);
        end

        // Basic transfer
        wr(16'h0011); wr(16'h0022); wr(16'h0033); wr(16'h0044); wr(16'h0055);
        chk("basic_count", fifo_count, 5);
        transfer(16'h0003, 3, 1'b0);

        // Short buffer: request ignored
        wr(16'h0101); wr(16'h0202); wr(16'h0303);
        gpp_send_req = 1'b1;
        dest_id = 16'h0007;
        tick();
        gpp_send_req = 1'b0;
        tick();
        chk("short_tx_req", tx_req, 0);
        chk("short_busy", tx_busy, 0);
        chk("short_count", fifo_count, 3);
        wr(16'h0404); wr(16'h0505);
        transfer(16'h0007, 0, 1'b0);

        // Overflow and pointer wrap
        for (int i = 0; i < 17; i++) wr(16'(16'h1000 + i));
        chk("ovf_count", fifo_count, 16);
        transfer(16'h0010, 1, 1'b0);
        for (int i = 0; i < 5; i++) wr(16'(16'h2000 + i));
        transfer(16'h0011, 2, 1'b0);
        for (int i = 0; i < 5; i++) wr(16'(16'h2100 + i));
        transfer(16'h0012, 0, 1'b0);
        transfer(16'h0013, 0, 1'b0);
        transfer(16'h0014, 0, 1'b0);
        for (int i = 0; i < 4; i++) wr(16'(16'h4000 + i));
        chk("cw_pre_count", fifo_count, 5);

        // Concurrent write and pop
        transfer(16'h0020, 1, 1'b1);
        chk("cw_post_count", fifo_count, 5);
        transfer(16'h0021, 0, 1'b0);

        // Reset mid-SEND after the second packet
        for (int i = 0; i < 5; i++) wr(16'(16'h3000 + i));
        gpp_send_req = 1'b1;
        dest_id = 16'h0030;
        tick();
        gpp_send_req = 1'b0;
        tx_grant = 1'b1;
        tick();
        tx_grant = 1'b0;
        expq.push_back({16'h0030, mq.pop_front()});
        expq.push_back({16'h0030, mq.pop_front()});
        mq.delete();
        tick();
        tick();
        #2 rst = 1'b0;
        #1;
        chk("rst_pkt", data_tx_packet, IDLE_PKT);
        chk("rst_busy", tx_busy, 0);
        chk("rst_count", fifo_count, 0);
        tick(); tick();
        rst = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        chk("rst_after_pkt", data_tx_packet, IDLE_PKT);
        chk("rst_after_count", fifo_count, 0);

        chk("expq_empty", expq.size(), 0);
        chk("flag_total", flags_seen, exp_flags);
        chk("ovf_total", ovf_seen, exp_ovf);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
